// File: rtl/apb_mig_bridge.sv
// APB completer that turns each APB access into a single MIG native-UI
// command/data transaction, one transaction in flight at a time.
module apb_mig_bridge #(
   parameter int unsigned     ADDR_W      = 32,
   parameter int unsigned     DATA_W      = 32,
   parameter int unsigned     APP_ADDR_W  = 28,
   parameter int unsigned     APP_DATA_W  = 128,
   parameter int unsigned     BURST_LEN   = 8,
   parameter longint unsigned MEM_BYTES   = 64'd268435456,
   parameter int unsigned     TIMEOUT_CYC = 1024
) (
   input  logic                    pclk_i,
   input  logic                    preset_i,
   input  logic [ADDR_W-1:0]       paddr_i,
   input  logic [DATA_W-1:0]       pwdata_i,
   input  logic                    pwrite_i,
   input  logic                    psel_i,
   input  logic                    penable_i,
   input  logic [DATA_W/8-1:0]     pstrb_i,
   output logic [DATA_W-1:0]       prdata_o,
   output logic                    pready_o,
   output logic                    pslverr_o,
   input  logic                    init_calib_complete_i,
   output logic [APP_ADDR_W-1:0]   app_addr_o,
   output logic [2:0]              app_cmd_o,
   output logic                    app_en_o,
   input  logic                    app_rdy_i,
   output logic [APP_DATA_W-1:0]   app_wdf_data_o,
   output logic [APP_DATA_W/8-1:0] app_wdf_mask_o,
   output logic                    app_wdf_wren_o,
   output logic                    app_wdf_end_o,
   input  logic                    app_wdf_rdy_i,
   input  logic [APP_DATA_W-1:0]   app_rd_data_i,
   input  logic                    app_rd_data_valid_i
);

   localparam int unsigned STRB_W     = DATA_W / 8;
   localparam int unsigned APP_BYTES  = APP_DATA_W / 8;
   localparam int unsigned NUM_LANES  = APP_DATA_W / DATA_W;
   localparam int unsigned LINE_SHIFT = $clog2(APP_BYTES);
   localparam int unsigned WORD_SHIFT = $clog2(STRB_W);
   localparam int unsigned LANE_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int unsigned TMO_W      = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam int unsigned DROP_W     = 4;

   localparam logic [2:0] CMD_WRITE = 3'b000;
   localparam logic [2:0] CMD_READ  = 3'b001;

   typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_CMD, S_RD_WAIT, S_RESP} state_t;

   state_t                  state, state_d;
   logic [LANE_W-1:0]       lane_q, lane_d;
   logic [TMO_W-1:0]        tmo_cnt, tmo_d;
   logic [DROP_W-1:0]       drop_cnt, drop_d;
   logic                    en_d, wren_d, pready_d, pslverr_d, drop_inc;
   logic [2:0]              cmd_d;
   logic [APP_ADDR_W-1:0]   addr_d;
   logic [APP_DATA_W-1:0]   wdata_d;
   logic [APP_BYTES-1:0]    wmask_d;
   logic [DATA_W-1:0]       prdata_d;

   logic [63:0]             addr_ext_c;
   logic                    cap_err_c;
   logic [APP_ADDR_W-1:0]   cap_addr_c;
   logic [LANE_W-1:0]       cap_lane_c;
   logic [APP_BYTES-1:0]    cap_mask_c;
   logic [DATA_W-1:0]       rd_slice_c;
   logic                    tmo_hit_c;
   logic                    drop_dec_c;

   // Decode of the presented APB address/strobes, used only at capture.
   always_comb begin
      addr_ext_c = 64'(paddr_i);
      cap_err_c  = !init_calib_complete_i || (addr_ext_c >= MEM_BYTES) ||
                   (paddr_i[1:0] != 2'b00);
      cap_addr_c = APP_ADDR_W'((addr_ext_c >> LINE_SHIFT) * 64'(BURST_LEN));
      cap_lane_c = LANE_W'(paddr_i >> WORD_SHIFT);
      cap_mask_c = '1;
      for (int b = 0; b < APP_BYTES; b++) begin
         if (((b / STRB_W) == int'(cap_lane_c)) && pstrb_i[b % STRB_W])
            cap_mask_c[b] = 1'b0;
      end
   end

   // Select the captured lane out of the MIG read word.
   always_comb begin
      rd_slice_c = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (lane_q == LANE_W'(i))
            rd_slice_c = app_rd_data_i[i*DATA_W +: DATA_W];
      end
   end

   assign tmo_hit_c  = (TIMEOUT_CYC != 0) && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
   assign drop_dec_c = app_rd_data_valid_i && (drop_cnt != '0);

   // Next-state and next-output logic; every register holds unless a state updates it.
   always_comb begin
      state_d   = state;
      en_d      = app_en_o;
      cmd_d     = app_cmd_o;
      addr_d    = app_addr_o;
      wdata_d   = app_wdf_data_o;
      wmask_d   = app_wdf_mask_o;
      wren_d    = app_wdf_wren_o;
      prdata_d  = prdata_o;
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      lane_d    = lane_q;
      tmo_d     = '0;
      drop_inc  = 1'b0;

      case (state)
         S_IDLE: begin
            if (psel_i && penable_i) begin
               lane_d   = cap_lane_c;
               addr_d   = cap_addr_c;
               prdata_d = '0;
               if (cap_err_c) begin
                  state_d   = S_RESP;
                  pready_d  = 1'b1;
                  pslverr_d = 1'b1;
               end else if (pwrite_i) begin
                  state_d = S_WR;
                  en_d    = 1'b1;
                  cmd_d   = CMD_WRITE;
                  wren_d  = 1'b1;
                  wdata_d = {NUM_LANES{pwdata_i}};
                  wmask_d = cap_mask_c;
               end else begin
                  state_d = S_RD_CMD;
                  en_d    = 1'b1;
                  cmd_d   = CMD_READ;
               end
            end
         end
         S_WR: begin
            tmo_d = tmo_cnt + TMO_W'(1);
            if (app_en_o && app_rdy_i)             en_d   = 1'b0;
            if (app_wdf_wren_o && app_wdf_rdy_i)   wren_d = 1'b0;
            if (!en_d && !wren_d) begin
               state_d  = S_RESP;
               pready_d = 1'b1;
            end else if (tmo_hit_c) begin
               en_d      = 1'b0;
               wren_d    = 1'b0;
               state_d   = S_RESP;
               pready_d  = 1'b1;
               pslverr_d = 1'b1;
               prdata_d  = '0;
            end
         end
         S_RD_CMD: begin
            tmo_d = tmo_cnt + TMO_W'(1);
            if (app_rdy_i) begin
               en_d    = 1'b0;
               state_d = S_RD_WAIT;
            end
            if (tmo_hit_c) begin
               // An accepted command still owes us a read beat; remember to discard it.
               drop_inc  = app_rdy_i;
               en_d      = 1'b0;
               state_d   = S_RESP;
               pready_d  = 1'b1;
               pslverr_d = 1'b1;
               prdata_d  = '0;
            end
         end
         S_RD_WAIT: begin
            tmo_d = tmo_cnt + TMO_W'(1);
            if (app_rd_data_valid_i && (drop_cnt == '0)) begin
               prdata_d = rd_slice_c;
               state_d  = S_RESP;
               pready_d = 1'b1;
            end else if (tmo_hit_c) begin
               drop_inc  = 1'b1;
               state_d   = S_RESP;
               pready_d  = 1'b1;
               pslverr_d = 1'b1;
               prdata_d  = '0;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      drop_d = drop_cnt;
      if (drop_inc && (drop_cnt != '1)) drop_d = drop_d + DROP_W'(1);
      if (drop_dec_c)                   drop_d = drop_d - DROP_W'(1);
   end

   // State and registered outputs.
   always_ff @(posedge pclk_i) begin
      if (preset_i) begin
         state          <= S_IDLE;
         app_en_o       <= 1'b0;
         app_cmd_o      <= 3'b000;
         app_addr_o     <= '0;
         app_wdf_data_o <= '0;
         app_wdf_mask_o <= '0;
         app_wdf_wren_o <= 1'b0;
         app_wdf_end_o  <= 1'b0;
         prdata_o       <= '0;
         pready_o       <= 1'b0;
         pslverr_o      <= 1'b0;
         lane_q         <= '0;
         tmo_cnt        <= '0;
         drop_cnt       <= '0;
      end else begin
         state          <= state_d;
         app_en_o       <= en_d;
         app_cmd_o      <= cmd_d;
         app_addr_o     <= addr_d;
         app_wdf_data_o <= wdata_d;
         app_wdf_mask_o <= wmask_d;
         app_wdf_wren_o <= wren_d;
         app_wdf_end_o  <= wren_d;
         prdata_o       <= prdata_d;
         pready_o       <= pready_d;
         pslverr_o      <= pslverr_d;
         lane_q         <= lane_d;
         tmo_cnt        <= tmo_d;
         drop_cnt       <= drop_d;
      end
   end

endmodule

// File: tb/tb_apb_mig_bridge.sv
// Directed bench for apb_mig_bridge with an inline MIG responder.
module tb_apb_mig_bridge;

   localparam int unsigned TMO = 32;

   logic          clk = 1'b0;
   logic          preset_i;
   logic [31:0]   paddr_i, pwdata_i;
   logic          pwrite_i, psel_i, penable_i;
   logic [3:0]    pstrb_i;
   logic [31:0]   prdata_o;
   logic          pready_o, pslverr_o;
   logic          init_calib_complete_i;
   logic [27:0]   app_addr_o;
   logic [2:0]    app_cmd_o;
   logic          app_en_o, app_rdy_i;
   logic [127:0]  app_wdf_data_o;
   logic [15:0]   app_wdf_mask_o;
   logic          app_wdf_wren_o, app_wdf_end_o, app_wdf_rdy_i;
   logic [127:0]  app_rd_data_i;
   logic          app_rd_data_valid_i;

   always #5 clk = ~clk;

   apb_mig_bridge #(.TIMEOUT_CYC(TMO)) dut (
      .pclk_i(clk), .preset_i(preset_i), .paddr_i(paddr_i), .pwdata_i(pwdata_i),
      .pwrite_i(pwrite_i), .psel_i(psel_i), .penable_i(penable_i), .pstrb_i(pstrb_i),
      .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
      .init_calib_complete_i(init_calib_complete_i), .app_addr_o(app_addr_o),
      .app_cmd_o(app_cmd_o), .app_en_o(app_en_o), .app_rdy_i(app_rdy_i),
      .app_wdf_data_o(app_wdf_data_o), .app_wdf_mask_o(app_wdf_mask_o),
      .app_wdf_wren_o(app_wdf_wren_o), .app_wdf_end_o(app_wdf_end_o),
      .app_wdf_rdy_i(app_wdf_rdy_i), .app_rd_data_i(app_rd_data_i),
      .app_rd_data_valid_i(app_rd_data_valid_i));

   int n_checks = 0;
   int n_errors = 0;

   // MIG responder knobs and per-access observations.
   int            cmd_stall, wdf_stall, rd_lat, stale_at;
   logic [127:0]  rd_word, stale_word;
   int            lat, cmd_acc, wdf_acc;
   logic          traffic;
   logic [27:0]   rec_addr;
   logic [2:0]    rec_cmd;
   logic [127:0]  rec_data;
   logic [15:0]   rec_mask;
   logic [31:0]   got_rdata;
   logic          got_err;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One APB transfer; plays the MIG side until pready or max_cyc access cycles.
   task automatic apb_run(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic wr, input logic [3:0] strb, input int max_cyc);
      int rd_cnt;
      rd_cnt = -1;
      cmd_acc = 0; wdf_acc = 0; traffic = 1'b0; lat = 0;
      rec_addr = '0; rec_cmd = '0; rec_data = '0; rec_mask = '0;
      paddr_i = addr; pwdata_i = wdata; pwrite_i = wr; pstrb_i = strb;
      psel_i = 1'b1; penable_i = 1'b0;
      tick();
      penable_i = 1'b1;
      for (int cyc = 1; cyc <= max_cyc; cyc++) begin
         app_rdy_i           = (cyc > cmd_stall);
         app_wdf_rdy_i       = (cyc > wdf_stall);
         app_rd_data_valid_i = 1'b0;
         if (rd_cnt == 0) begin
            app_rd_data_valid_i = 1'b1;
            app_rd_data_i       = rd_word;
            rd_cnt              = -1;
         end else if (rd_cnt > 0) begin
            rd_cnt--;
         end
         if (cyc == stale_at) begin
            app_rd_data_valid_i = 1'b1;
            app_rd_data_i       = stale_word;
         end
         traffic = traffic | app_en_o | app_wdf_wren_o;
         if (app_en_o && app_rdy_i) begin
            cmd_acc++;
            rec_addr = app_addr_o;
            rec_cmd  = app_cmd_o;
            if (app_cmd_o == 3'b001 && rd_lat >= 0) rd_cnt = rd_lat;
         end
         if (app_wdf_wren_o && app_wdf_rdy_i) begin
            wdf_acc++;
            rec_data = app_wdf_data_o;
            rec_mask = app_wdf_mask_o;
         end
         if (pready_o) begin
            lat = cyc;
            break;
         end
         tick();
      end
      got_rdata = prdata_o;
      got_err   = pslverr_o;
      check("pready_seen", 128'(pready_o), 128'd1);
      tick();
      psel_i = 1'b0; penable_i = 1'b0;
      app_rdy_i = 1'b1; app_wdf_rdy_i = 1'b1; app_rd_data_valid_i = 1'b0;
      check("pready_one_cycle", 128'(pready_o), 128'd0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_pready"},  128'(pready_o),       128'd0);
      check({tag, "_pslverr"}, 128'(pslverr_o),      128'd0);
      check({tag, "_prdata"},  128'(prdata_o),       128'd0);
      check({tag, "_app_en"},  128'(app_en_o),       128'd0);
      check({tag, "_app_cmd"}, 128'(app_cmd_o),      128'd0);
      check({tag, "_app_addr"},128'(app_addr_o),     128'd0);
      check({tag, "_wdata"},   app_wdf_data_o,       128'd0);
      check({tag, "_wmask"},   128'(app_wdf_mask_o), 128'd0);
      check({tag, "_wren"},    128'(app_wdf_wren_o), 128'd0);
      check({tag, "_wend"},    128'(app_wdf_end_o),  128'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      preset_i = 1'b1; paddr_i = '0; pwdata_i = '0; pwrite_i = 1'b0; psel_i = 1'b0;
      penable_i = 1'b0; pstrb_i = '0; init_calib_complete_i = 1'b1;
      app_rdy_i = 1'b1; app_wdf_rdy_i = 1'b1; app_rd_data_i = '0; app_rd_data_valid_i = 1'b0;
      cmd_stall = 0; wdf_stall = 0; rd_lat = -1; stale_at = -1;
      rd_word = '0; stale_word = '0;
      tick(); tick();
      check_outputs_zero("reset");
      preset_i = 1'b0;
      tick();

      // Basic write to lane 1.
      apb_run(32'h24, 32'hDEADBEEF, 1'b1, 4'hF, 50);
      check("wr_latency", 128'(lat),      128'd3);
      check("wr_err",     128'(got_err),  128'd0);
      check("wr_cmd_acc", 128'(cmd_acc),  128'd1);
      check("wr_wdf_acc", 128'(wdf_acc),  128'd1);
      check("wr_addr",    128'(rec_addr), 128'h10);
      check("wr_cmd",     128'(rec_cmd),  128'd0);
      check("wr_data",    rec_data,       128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF);
      check("wr_mask",    128'(rec_mask), 128'hFF0F);

      // Read from lane 2 with 20-cycle MIG latency.
      rd_lat = 20;
      rd_word = 128'hAAAAAAAA_12345678_BBBBBBBB_CCCCCCCC;
      apb_run(32'h28, 32'h0, 1'b0, 4'h0, 80);
      check("rd_latency", 128'(lat),       128'd24);
      check("rd_data",    128'(got_rdata), 128'h12345678);
      check("rd_err",     128'(got_err),   128'd0);
      check("rd_addr",    128'(rec_addr),  128'h10);
      check("rd_cmd",     128'(rec_cmd),   128'd1);
      rd_lat = -1;

      // Command stalls 5 cycles, data stalls 9; partial strobes on lane 3.
      cmd_stall = 5; wdf_stall = 9;
      apb_run(32'h3C, 32'h11223344, 1'b1, 4'b0101, 50);
      check("stall_latency", 128'(lat),      128'd11);
      check("stall_cmd_acc", 128'(cmd_acc),  128'd1);
      check("stall_wdf_acc", 128'(wdf_acc),  128'd1);
      check("stall_err",     128'(got_err),  128'd0);
      check("stall_addr",    128'(rec_addr), 128'h18);
      check("stall_mask",    128'(rec_mask), 128'hAFFF);
      check("stall_data",    rec_data,       128'h11223344_11223344_11223344_11223344);

      // Data accepted before command.
      cmd_stall = 7; wdf_stall = 0;
      apb_run(32'h40, 32'h0BADF00D, 1'b1, 4'hF, 50);
      check("dfirst_latency", 128'(lat),     128'd9);
      check("dfirst_cmd_acc", 128'(cmd_acc), 128'd1);
      check("dfirst_wdf_acc", 128'(wdf_acc), 128'd1);
      cmd_stall = 0;

      // Zero strobes: fully masked, still OKAY.
      apb_run(32'h0, 32'h55AA55AA, 1'b1, 4'h0, 50);
      check("nostrb_mask",    128'(rec_mask), 128'hFFFF);
      check("nostrb_err",     128'(got_err),  128'd0);
      check("nostrb_latency", 128'(lat),      128'd3);

      // Error captures: no MIG traffic, pslverr with zero data.
      init_calib_complete_i = 1'b0;
      apb_run(32'h24, 32'h1, 1'b1, 4'hF, 20);
      check("nocal_err",     128'(got_err),   128'd1);
      check("nocal_rdata",   128'(got_rdata), 128'd0);
      check("nocal_traffic", 128'(traffic),   128'd0);
      check("nocal_latency", 128'(lat),       128'd2);
      init_calib_complete_i = 1'b1;

      rd_word = 128'h0;
      apb_run(32'h1000_0000, 32'h0, 1'b0, 4'h0, 20);
      check("range_err",     128'(got_err), 128'd1);
      check("range_traffic", 128'(traffic), 128'd0);

      apb_run(32'h2, 32'h0, 1'b0, 4'h0, 20);
      check("align_err",     128'(got_err), 128'd1);
      check("align_traffic", 128'(traffic), 128'd0);

      // Read accepted but never answered: timeout.
      rd_lat = -1;
      apb_run(32'h30, 32'h0, 1'b0, 4'h0, 80);
      check("tmo_latency", 128'(lat),       128'd34);
      check("tmo_err",     128'(got_err),   128'd1);
      check("tmo_rdata",   128'(got_rdata), 128'd0);
      check("tmo_cmd_acc", 128'(cmd_acc),   128'd1);

      // The late beat lands during the next read and must be discarded.
      stale_at = 3; stale_word = 128'hDEAD0000_DEAD1111_DEAD2222_DEAD3333;
      rd_lat = 4;   rd_word    = 128'h00000000_CAFEF00D_00000000_00000000;
      apb_run(32'h28, 32'h0, 1'b0, 4'h0, 40);
      check("drop_rdata",   128'(got_rdata), 128'hCAFEF00D);
      check("drop_err",     128'(got_err),   128'd0);
      check("drop_latency", 128'(lat),       128'd8);
      stale_at = -1; rd_lat = -1;

      // Reset while waiting for read data.
      paddr_i = 32'h28; pwrite_i = 1'b0; psel_i = 1'b1; penable_i = 1'b0;
      tick();
      penable_i = 1'b1;
      tick(); tick(); tick();
      check("pre_rst_addr", 128'(app_addr_o), 128'h10);
      check("pre_rst_cmd",  128'(app_cmd_o),  128'd1);
      preset_i = 1'b1;
      tick();
      check_outputs_zero("midrst");
      preset_i = 1'b0; psel_i = 1'b0; penable_i = 1'b0;
      tick();
      apb_run(32'h24, 32'hFEEDFACE, 1'b1, 4'hF, 50);
      check("postrst_latency", 128'(lat),      128'd3);
      check("postrst_err",     128'(got_err),  128'd0);
      check("postrst_mask",    128'(rec_mask), 128'hFF0F);

      tick();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
